dma_sram_dram_ctrl: RTL and testbench
=====================================

Name: dma_sram_dram_ctrl

Overview:
- DMA controller between the single-cycle core's DMA command outputs and the on-chip SRAM / external DRAM port.
- Accepts one d2s (DRAM->SRAM) or s2d (SRAM->DRAM) command, copies dmaWidth 32-bit words one at a time, and holds stall high to freeze the core while it owns the SRAM.
- The top level muxes the SRAM to this block whenever stall=1.

Parameters:
- SRAM_AW, 14, SRAM word-address width; SRAM word address = byte address[SRAM_AW+1:2].
- WIDTH_BITS, 10, width of the word-count field dmaWidth.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- dmaCmd  in  2  00 none, 01 d2s, 10 s2d, 11 ignored
- dmaSrcAddress  in  32  source byte address (DRAM for d2s, SRAM for s2d), word aligned
- dmaDstAddress  in  32  destination byte address (SRAM for d2s, DRAM for s2d), word aligned
- dmaWidth  in  WIDTH_BITS  number of words to copy
- sramReadData  in  32  SRAM read data, combinational from sramAddress
- dramReadData  in  32  DRAM read data, valid only when dramValid=1
- sramAddress  out  SRAM_AW  SRAM word address
- sramWriteData  out  32  SRAM write data
- sramWriteEnable  out  1  SRAM write strobe, written on the rising edge
- dramAddress  out  32  DRAM byte address
- dramWriteData  out  32  DRAM write data
- dramWriteEnable  out  1  DRAM write request (level)
- dramReadEnable  out  1  DRAM read request (level)
- dramValid  in  1  one-cycle DRAM completion pulse for the outstanding request
- stall  out  1  core freeze; 1 while the block is not IDLE

Behaviour:
- States: IDLE, D2S_REQ, S2D_RD, S2D_WR.
- stall = (state != IDLE). It is a decoded state register, never combinational from dmaCmd.
- Reset (reset=0, any time including mid-transfer): state=IDLE, counters and address registers=0, all outputs 0. The transfer is aborted and no completion is reported.

Acceptance:
- In IDLE, on a rising edge with dmaCmd in {01,10} and dmaWidth != 0, latch src, dst and count=dmaWidth.
  - 01 -> D2S_REQ; 10 -> S2D_RD.
  - stall rises in the cycle after the command cycle, so the core retires the DMA instruction in the command cycle and freezes on the next one.
- dmaCmd=11, or dmaWidth=0: ignored; the block stays in IDLE and stall stays 0.
- dmaCmd while not IDLE is ignored. The core drives 0 while stalled; the bench must still check this.

D2S_REQ:
- dramReadEnable=1, dramAddress=src, held stable until dramValid.
- In the dramValid cycle: sramWriteEnable=1, sramAddress=dst[SRAM_AW+1:2], sramWriteData=dramReadData, all combinational.
- At that edge: src+=4, dst+=4, count-=1. If count was 1 -> IDLE, else stay in D2S_REQ with the new address driven the following cycle.

S2D_RD:
- One cycle. sramAddress=src[SRAM_AW+1:2]; latch sramReadData into a data register; -> S2D_WR.

S2D_WR:
- dramWriteEnable=1, dramAddress=dst, dramWriteData=data register, held until dramValid.
- At the dramValid edge: src+=4, dst+=4, count-=1. If count was 1 -> IDLE, else -> S2D_RD.

Output defaults and DRAM rules:
- Outside the states above, every output is 0. dramReadEnable and dramWriteEnable are never 1 together.
- dramValid is ignored in IDLE and S2D_RD.
- Addresses wrap modulo 2^32; the SRAM address is truncated to SRAM_AW bits, with no error.

Latency:
- d2s of N words with DRAM latency L (dramValid in the L-th request cycle): stall high N*L cycles.
- s2d of N words: stall high N*(L+1) cycles.
- Maximum transfer is 2^WIDTH_BITS-1 = 1023 words.

Test Plan:
- d2s, src=0x100, dst=0x40, width=4, DRAM latency 3, DRAM words A0..A3 -> SRAM words 0x10..0x13 = A0..A3. stall high exactly 12 cycles, starting the cycle after the command. dramAddress steps 0x100, 0x104, 0x108, 0x10C.
- s2d, src=0x20, dst=0x2000, width=3, SRAM[8..10]=B0..B2, latency 1 -> DRAM writes B0..B2 at 0x2000, 0x2004, 0x2008. stall high 6 cycles; read enable never asserted.
- dmaCmd=01 with width=0, and dmaCmd=11 with width=5 -> stall stays 0; no SRAM or DRAM enables.
- Spurious dramValid pulses in IDLE and during S2D_RD -> no SRAM write, no count change.
- reset driven low in the 3rd word of a 5-word d2s -> stall, enables and addresses go to 0 immediately without a clock. After release, a new 1-word d2s completes correctly.
- Back-to-back: a d2s of 2 words, then an s2d issued in the first unstalled cycle -> both complete. stall has exactly one low cycle between them, and data ordering is preserved.

Source files
------------

// File: rtl/dma_sram_dram_if.sv
// Bus between the DMA controller and the core / SRAM / DRAM side.
// The controller connects through the master modport, and the environment connects through slave.
interface dma_sram_dram_if #(
  parameter int SRAM_AW    = 14,
  parameter int WIDTH_BITS = 10
);
  // Command from the core
  logic [1:0]            dmaCmd;
  logic [31:0]           dmaSrcAddress;
  logic [31:0]           dmaDstAddress;
  logic [WIDTH_BITS-1:0] dmaWidth;

  // SRAM port (muxed to this block while stall=1)
  logic [31:0]           sramReadData;
  logic [SRAM_AW-1:0]    sramAddress;
  logic [31:0]           sramWriteData;
  logic                  sramWriteEnable;

  // DRAM port
  logic [31:0]           dramReadData;
  logic [31:0]           dramAddress;
  logic [31:0]           dramWriteData;
  logic                  dramWriteEnable;
  logic                  dramReadEnable;
  logic                  dramValid;

  // Core freeze
  logic                  stall;

  modport master (
    input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
    input  sramReadData, dramReadData, dramValid,
    output sramAddress, sramWriteData, sramWriteEnable,
    output dramAddress, dramWriteData, dramWriteEnable, dramReadEnable,
    output stall
  );

  modport slave (
    output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
    output sramReadData, dramReadData, dramValid,
    input  sramAddress, sramWriteData, sramWriteEnable,
    input  dramAddress, dramWriteData, dramWriteEnable, dramReadEnable,
    input  stall
  );
endinterface

// File: rtl/dma_sram_dram_ctrl.sv
// Word-at-a-time DMA between on-chip SRAM and external DRAM.
// The block accepts one command while it is idle. It freezes the core through stall until the last word completes.
module dma_sram_dram_ctrl #(
  parameter int SRAM_AW    = 14,
  parameter int WIDTH_BITS = 10
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active low
  dma_sram_dram_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D2S_REQ = 2'd1,
    S2D_RD  = 2'd2,
    S2D_WR  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_D2S = 2'b01;
  localparam logic [1:0] CMD_S2D = 2'b10;

  state_e                state_q, state_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]           data_q, data_d;

  logic                  last_word;
  assign last_word = (cnt_q == WIDTH_BITS'(1));

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed in always_comb.
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state and register updates: command acceptance, per-word advance, SRAM read capture
  always_comb begin
    // NOTE: hold-current defaults on every path keep this block free of latches.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if ((bus.dmaCmd == CMD_D2S || bus.dmaCmd == CMD_S2D) && bus.dmaWidth != '0) begin
          src_d   = bus.dmaSrcAddress;
          dst_d   = bus.dmaDstAddress;
          cnt_d   = bus.dmaWidth;
          state_d = (bus.dmaCmd == CMD_D2S) ? D2S_REQ : S2D_RD;
        end
      end
      D2S_REQ: begin
        if (bus.dramValid) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - WIDTH_BITS'(1);
          state_d = last_word ? IDLE : D2S_REQ;
        end
      end
      S2D_RD: begin
        // The SRAM read is combinational, so one cycle is enough to capture the word.
        data_d  = bus.sramReadData;
        state_d = S2D_WR;
      end
      S2D_WR: begin
        if (bus.dramValid) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - WIDTH_BITS'(1);
          state_d = last_word ? IDLE : S2D_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Every output is 0 unless the current state drives it.
  always_comb begin
    bus.sramAddress     = '0;
    bus.sramWriteData   = '0;
    bus.sramWriteEnable = 1'b0;
    bus.dramAddress     = '0;
    bus.dramWriteData   = '0;
    bus.dramWriteEnable = 1'b0;
    bus.dramReadEnable  = 1'b0;
    bus.stall           = (state_q != IDLE);
    case (state_q)
      D2S_REQ: begin
        bus.dramReadEnable = 1'b1;
        bus.dramAddress    = src_q;
        if (bus.dramValid) begin
          bus.sramWriteEnable = 1'b1;
          bus.sramAddress     = dst_q[SRAM_AW+1:2];
          bus.sramWriteData   = bus.dramReadData;
        end
      end
      S2D_RD: begin
        bus.sramAddress = src_q[SRAM_AW+1:2];
      end
      S2D_WR: begin
        bus.dramWriteEnable = 1'b1;
        bus.dramAddress     = dst_q;
        bus.dramWriteData   = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_sram_dram_ctrl.sv
// Directed bench for dma_sram_dram_ctrl, with behavioural SRAM and a fixed-latency DRAM responder.
// Inputs change and outputs are sampled one time unit after the falling edge.
module tb_dma_sram_dram_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_sram_dram_if bus ();

  dma_sram_dram_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] sram_mem [0:16383];
  logic [31:0] dram_mem [0:1023];
  logic        mv;    // responder completion pulse
  logic        spur;  // injected stray completion pulse

  assign bus.sramReadData = sram_mem[bus.sramAddress];
  assign bus.dramReadData = dram_mem[bus.dramAddress[11:2]];
  assign bus.dramValid    = mv | spur;

  int vectors, miscompares;
  int lat, dcnt, spur_mode;  // spur_mode: 0 none, 1 in idle, 2 in SRAM-read cycles
  int stall_cycles, sram_we_cnt, rd_cycles, wr_cycles, both_cnt;
  logic [31:0] rd_log [$];
  logic [63:0] wr_log [$];

  task automatic clear_stats();
    stall_cycles = 0; sram_we_cnt = 0; rd_cycles = 0; wr_cycles = 0;
    rd_log.delete(); wr_log.delete();
  endtask

  // One clock cycle: commit at the rising edge, then emulate DRAM and sample at the falling edge
  task automatic tick();
    logic        pend_we;
    logic [13:0] pend_a;
    logic [31:0] pend_d;
    pend_we = bus.sramWriteEnable;
    pend_a  = bus.sramAddress;
    pend_d  = bus.sramWriteData;
    if (bus.dramWriteEnable && bus.dramValid) wr_log.push_back({bus.dramAddress, bus.dramWriteData});
    if (bus.dramReadEnable && bus.dramValid) rd_log.push_back(bus.dramAddress);
    @(posedge clk);
    if (pend_we) sram_mem[pend_a] = pend_d;
    @(negedge clk);
    if (mv) dcnt = 0;
    mv = 1'b0;
    if (bus.dramReadEnable || bus.dramWriteEnable) begin
      dcnt++;
      if (dcnt == lat) mv = 1'b1;
    end else dcnt = 0;
    spur = (spur_mode == 1 && !bus.stall) ||
           (spur_mode == 2 && bus.stall && !bus.dramReadEnable && !bus.dramWriteEnable);
    #1;
    if (bus.stall) stall_cycles++;
    if (bus.sramWriteEnable) sram_we_cnt++;
    if (bus.dramReadEnable) rd_cycles++;
    if (bus.dramWriteEnable) wr_cycles++;
    if (bus.dramReadEnable && bus.dramWriteEnable) both_cnt++;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                       input logic [9:0] w);
    bus.dmaCmd = cmd; bus.dmaSrcAddress = src; bus.dmaDstAddress = dst; bus.dmaWidth = w;
    tick();
    bus.dmaCmd = 2'b00; bus.dmaSrcAddress = '0; bus.dmaDstAddress = '0; bus.dmaWidth = '0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.stall && n < budget) begin tick(); n++; end
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL %s_timeout: stall still %b after %0d cycles", name, bus.stall, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mv = 1'b0; spur = 1'b0; dcnt = 0; lat = 1; spur_mode = 0;
    bus.dmaCmd = '0; bus.dmaSrcAddress = '0; bus.dmaDstAddress = '0; bus.dmaWidth = '0;
    @(negedge clk); #1;
    vectors += 4;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    if ({bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable} !== 3'b000) begin
      miscompares++; $display("FAIL rst_enables: got %b want 000", {bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable});
    end
    if (bus.dramAddress !== 32'h0) begin miscompares++; $display("FAIL rst_dram_addr: got %h want 0", bus.dramAddress); end
    if (bus.sramAddress !== 14'h0) begin miscompares++; $display("FAIL rst_sram_addr: got %h want 0", bus.sramAddress); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_d2s();
    lat = 3;
    for (int i = 0; i < 4; i++) dram_mem[16'h40 + i] = 32'hA0A0_0000 + i;
    clear_stats();
    vectors++;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL d2s_cmd_cycle_stall: got %b want 0", bus.stall); end
    issue(2'b01, 32'h100, 32'h40, 10'd4);
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL d2s_stall_rise: got %b want 1", bus.stall); end
    // A second command while busy must be ignored.
    bus.dmaCmd = 2'b10; bus.dmaSrcAddress = 32'h999; bus.dmaDstAddress = 32'h777; bus.dmaWidth = 10'd7;
    for (int i = 0; i < 5; i++) tick();
    bus.dmaCmd = 2'b00; bus.dmaWidth = '0;
    wait_idle(60, "d2s");
    tick();
    vectors += 5;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL d2s_busy_cmd_ignored: stall %b want 0", bus.stall); end
    if (stall_cycles != 12) begin miscompares++; $display("FAIL d2s_stall_len: got %0d want 12", stall_cycles); end
    if (wr_cycles != 0) begin miscompares++; $display("FAIL d2s_no_dram_wr: got %0d want 0", wr_cycles); end
    if (rd_log.size() != 4) begin miscompares++; $display("FAIL d2s_rd_count: got %0d want 4", rd_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (rd_log[i] !== 32'h100 + 32'(4 * i)) begin
          miscompares++; $display("FAIL d2s_dram_addr%0d: got %h want %h", i, rd_log[i], 32'h100 + 32'(4 * i));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (sram_mem[14'h10 + i] !== 32'hA0A0_0000 + i) begin
        miscompares++; $display("FAIL d2s_sram%0d: got %h want %h", i, sram_mem[14'h10 + i], 32'hA0A0_0000 + i);
      end
    end
    if (sram_we_cnt != 4) begin miscompares++; $display("FAIL d2s_sram_we: got %0d want 4", sram_we_cnt); end
  endtask

  task automatic test_s2d();
    logic [63:0] exp;
    lat = 1;
    for (int i = 0; i < 3; i++) sram_mem[8 + i] = 32'hB0B0_0000 + i;
    clear_stats();
    issue(2'b10, 32'h20, 32'h2000, 10'd3);
    wait_idle(40, "s2d");
    vectors += 4;
    if (stall_cycles != 6) begin miscompares++; $display("FAIL s2d_stall_len: got %0d want 6", stall_cycles); end
    if (rd_cycles != 0) begin miscompares++; $display("FAIL s2d_no_rd_en: got %0d want 0", rd_cycles); end
    if (sram_we_cnt != 0) begin miscompares++; $display("FAIL s2d_no_sram_we: got %0d want 0", sram_we_cnt); end
    if (wr_log.size() != 3) begin miscompares++; $display("FAIL s2d_wr_count: got %0d want 3", wr_log.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        exp = {32'h2000 + 32'(4 * i), 32'hB0B0_0000 + 32'(i)};
        vectors++;
        if (wr_log[i] !== exp) begin miscompares++; $display("FAIL s2d_wr%0d: got %h want %h", i, wr_log[i], exp); end
      end
    end
  endtask

  task automatic test_ignored();
    clear_stats();
    issue(2'b01, 32'h100, 32'h40, 10'd0);
    for (int i = 0; i < 3; i++) tick();
    issue(2'b11, 32'h100, 32'h40, 10'd5);
    for (int i = 0; i < 3; i++) tick();
    vectors += 4;
    if (stall_cycles != 0) begin miscompares++; $display("FAIL ign_stall: got %0d want 0", stall_cycles); end
    if (sram_we_cnt != 0) begin miscompares++; $display("FAIL ign_sram_we: got %0d want 0", sram_we_cnt); end
    if (rd_cycles != 0) begin miscompares++; $display("FAIL ign_dram_rd: got %0d want 0", rd_cycles); end
    if (wr_cycles != 0) begin miscompares++; $display("FAIL ign_dram_wr: got %0d want 0", wr_cycles); end
  endtask

  task automatic test_spurious();
    logic [63:0] exp;
    spur_mode = 1;
    clear_stats();
    for (int i = 0; i < 3; i++) tick();
    vectors += 2;
    if (stall_cycles != 0) begin miscompares++; $display("FAIL spur_idle_stall: got %0d want 0", stall_cycles); end
    if (sram_we_cnt != 0) begin miscompares++; $display("FAIL spur_idle_sram_we: got %0d want 0", sram_we_cnt); end
    spur_mode = 2; lat = 2;
    sram_mem[14'h30] = 32'hE0E0_0000; sram_mem[14'h31] = 32'hE0E0_0001;
    clear_stats();
    issue(2'b10, 32'hC0, 32'h4000, 10'd2);
    wait_idle(40, "spur_s2d");
    spur_mode = 0; spur = 1'b0;
    vectors += 3;
    if (stall_cycles != 6) begin miscompares++; $display("FAIL spur_rd_stall_len: got %0d want 6", stall_cycles); end
    if (sram_we_cnt != 0) begin miscompares++; $display("FAIL spur_rd_sram_we: got %0d want 0", sram_we_cnt); end
    if (wr_log.size() != 2) begin miscompares++; $display("FAIL spur_rd_wr_count: got %0d want 2", wr_log.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        exp = {32'h4000 + 32'(4 * i), 32'hE0E0_0000 + 32'(i)};
        vectors++;
        if (wr_log[i] !== exp) begin miscompares++; $display("FAIL spur_rd_wr%0d: got %h want %h", i, wr_log[i], exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    lat = 2;
    for (int i = 0; i < 5; i++) begin
      dram_mem[16'h80 + i] = 32'hD0D0_0000 + i;
      sram_mem[14'h100 + i] = 32'h0;
    end
    clear_stats();
    issue(2'b01, 32'h200, 32'h400, 10'd5);
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (bus.dramAddress !== 32'h208) begin miscompares++; $display("FAIL rmid_third_addr: got %h want 00000208", bus.dramAddress); end
    #2 reset = 1'b0;
    mv = 1'b0; dcnt = 0;
    #1;
    vectors += 4;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL rmid_stall: got %b want 0", bus.stall); end
    if ({bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable} !== 3'b000) begin
      miscompares++; $display("FAIL rmid_enables: got %b want 000", {bus.dramReadEnable, bus.dramWriteEnable, bus.sramWriteEnable});
    end
    if (bus.dramAddress !== 32'h0) begin miscompares++; $display("FAIL rmid_dram_addr: got %h want 0", bus.dramAddress); end
    if (bus.sramAddress !== 14'h0) begin miscompares++; $display("FAIL rmid_sram_addr: got %h want 0", bus.sramAddress); end
    tick(); tick();
    reset = 1'b1;
    tick();
    vectors += 4;
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL rmid_after_release: stall %b want 0", bus.stall); end
    if (sram_mem[14'h100] !== 32'hD0D0_0000) begin miscompares++; $display("FAIL rmid_word0: got %h want d0d00000", sram_mem[14'h100]); end
    if (sram_mem[14'h101] !== 32'hD0D0_0001) begin miscompares++; $display("FAIL rmid_word1: got %h want d0d00001", sram_mem[14'h101]); end
    if (sram_mem[14'h102] !== 32'h0) begin miscompares++; $display("FAIL rmid_word2_aborted: got %h want 0", sram_mem[14'h102]); end
    dram_mem[16'h140] = 32'hF0F0_F0F0;
    clear_stats();
    issue(2'b01, 32'h500, 32'h600, 10'd1);
    wait_idle(20, "rmid_new");
    vectors += 2;
    if (sram_mem[14'h180] !== 32'hF0F0_F0F0) begin miscompares++; $display("FAIL rmid_new_data: got %h want f0f0f0f0", sram_mem[14'h180]); end
    if (stall_cycles != 2) begin miscompares++; $display("FAIL rmid_new_stall_len: got %0d want 2", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    lat = 1;
    dram_mem[16'hC0] = 32'hC0C0_0000; dram_mem[16'hC1] = 32'hC0C0_0001;
    clear_stats();
    issue(2'b01, 32'h300, 32'h80, 10'd2);
    wait_idle(20, "b2b_d2s");
    vectors++;
    if (stall_cycles != 2) begin miscompares++; $display("FAIL b2b_d2s_stall_len: got %0d want 2", stall_cycles); end
    issue(2'b10, 32'h80, 32'h3000, 10'd2);
    vectors++;
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL b2b_one_low_cycle: stall %b want 1", bus.stall); end
    wait_idle(20, "b2b_s2d");
    vectors += 2;
    if (stall_cycles != 6) begin miscompares++; $display("FAIL b2b_total_stall: got %0d want 6", stall_cycles); end
    if (wr_log.size() != 2) begin miscompares++; $display("FAIL b2b_wr_count: got %0d want 2", wr_log.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        exp = {32'h3000 + 32'(4 * i), 32'hC0C0_0000 + 32'(i)};
        vectors++;
        if (wr_log[i] !== exp) begin miscompares++; $display("FAIL b2b_wr%0d: got %h want %h", i, wr_log[i], exp); end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; both_cnt = 0;
    for (int i = 0; i < 16384; i++) sram_mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dram_mem[i] = 32'h0;
    test_reset();
    test_d2s();
    test_s2d();
    test_ignored();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (both_cnt != 0) begin miscompares++; $display("FAIL rd_wr_exclusive: got %0d overlapping cycles want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
